// File: rtl/prog_updown_counter.sv
// prog_updown_counter
//   Programmable up/down counter behind a chip-select/read/write register bus.
//   Bounce mode counts PLR->ULR->LLR->PLR (or PLR->LLR->ULR->PLR when
//   FIRST_DN is set). Wrap mode cycles LLR..ULR in one direction. Either mode
//   runs for CCR cycles and then pulses ec_out for one clock.
//
//   Optional feature macro: COUNTER_IRQ_EN adds a sticky irq_out that is set
//   by ec_out and cleared by a bus write to address 5.
//
// Ports
//   clk_in            clock, rising edge
//   reset_in          synchronous active-high reset
//   ncs_in/nwr_in/nrd_in  active-low chip select / write / read strobes
//   addr_in, din      register address and write data
//   dout              registered read data (1-cycle latency, holds otherwise)
//   start_in          start request, rising-edge detected
//   abort_in          abort level, stops a run on the next edge
//   count_out         current count
//   busy_out          run in progress
//   dir_out           direction of last step (1 = up)
//   err_out           limit configuration error (registered)
//   ec_out            one-cycle end-of-count pulse
//   irq_out           (COUNTER_IRQ_EN only) sticky end-of-count flag
module prog_updown_counter #(
    parameter int WIDTH  = 8,
    parameter int CYC_W  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk_in,
    input  logic              reset_in,
    input  logic              ncs_in,
    input  logic              nwr_in,
    input  logic              nrd_in,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [WIDTH-1:0]  din,
    output logic [WIDTH-1:0]  dout,
    input  logic              start_in,
    input  logic              abort_in,
    output logic [WIDTH-1:0]  count_out,
    output logic              busy_out,
    output logic              dir_out,
    output logic              err_out,
    output logic              ec_out
`ifdef COUNTER_IRQ_EN
    ,
    output logic              irq_out
`endif
);

    typedef enum logic [2:0] {S_IDLE, S_PH1, S_PH2, S_PH3, S_WRAP} state_t;

    localparam logic [ADDR_W-1:0] A_PLR  = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] A_ULR  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] A_LLR  = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] A_CCR  = ADDR_W'(3);
    localparam logic [ADDR_W-1:0] A_CTRL = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] A_STAT = ADDR_W'(5);
    localparam logic [ADDR_W-1:0] A_CNT  = ADDR_W'(6);
    localparam logic [ADDR_W-1:0] A_REM  = ADDR_W'(7);
    localparam logic [WIDTH-1:0]  ONE    = WIDTH'(1);
    localparam logic [CYC_W-1:0]  CONE   = CYC_W'(1);

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  plr_q, plr_d, ulr_q, ulr_d, llr_q, llr_d;
    logic [CYC_W-1:0]  ccr_q, ccr_d, rem_q, rem_d;
    logic [1:0]        ctrl_q, ctrl_d;
    logic [WIDTH-1:0]  cnt_q, cnt_d, dout_q, dout_d;
    logic              dir_q, dir_d, err_q, err_d, ec_q, ec_d;
    logic              start_q, start_d, wr_ign_q, wr_ign_d;

    logic              wr_en, rd_en, busy, first_dn, wrap, start_rise;
    logic [WIDTH-1:0]  t1, t2, tgt, nxt, rdata;
    logic              step_up, cyc_end;
    state_t            entry_st;

    assign wr_en      = ~ncs_in & ~nwr_in & nrd_in;
    assign rd_en      = ~ncs_in & ~nrd_in & nwr_in;
    assign busy       = (state_q != S_IDLE);
    assign first_dn   = ctrl_q[0];
    assign wrap       = ctrl_q[1];
    assign start_rise = start_in & ~start_q;
    // Phase targets: PH1 heads for t1, PH2 for t2, PH3 back to PLR.
    assign t1         = first_dn ? llr_q : ulr_q;
    assign t2         = first_dn ? ulr_q : llr_q;
    // When PLR already sits on the PH1 target, PH1 has zero length.
    assign entry_st   = (plr_q == t1) ? S_PH2 : S_PH1;

    always_comb begin
        rdata = '0;
        case (addr_in)
            A_PLR:   rdata = plr_q;
            A_ULR:   rdata = ulr_q;
            A_LLR:   rdata = llr_q;
            A_CCR:   rdata = WIDTH'(ccr_q);
            A_CTRL:  rdata = WIDTH'(ctrl_q);
            A_STAT:  rdata = WIDTH'({wr_ign_q, busy, err_q, dir_q});
            A_CNT:   rdata = cnt_q;
            A_REM:   rdata = WIDTH'(rem_q);
            default: rdata = '0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        plr_d    = plr_q;
        ulr_d    = ulr_q;
        llr_d    = llr_q;
        ccr_d    = ccr_q;
        ctrl_d   = ctrl_q;
        rem_d    = rem_q;
        cnt_d    = cnt_q;
        dir_d    = dir_q;
        dout_d   = dout_q;
        wr_ign_d = wr_ign_q;
        ec_d     = 1'b0;
        start_d  = start_in;
        err_d    = (plr_q < llr_q) | (plr_q > ulr_q) | (llr_q > ulr_q);
        step_up  = 1'b0;
        tgt      = plr_q;
        nxt      = cnt_q;
        cyc_end  = 1'b0;

        // Register bus
        if (wr_en) begin
            if (busy) begin
                wr_ign_d = 1'b1;
            end else begin
                case (addr_in)
                    A_PLR:   plr_d  = din;
                    A_ULR:   ulr_d  = din;
                    A_LLR:   llr_d  = din;
                    A_CCR:   ccr_d  = CYC_W'(din);
                    A_CTRL:  ctrl_d = din[1:0];
                    default: ;
                endcase
            end
        end
        if (rd_en) begin
            dout_d = rdata;
            if (addr_in == A_STAT) wr_ign_d = 1'b0;
        end

        // Counter FSM
        case (state_q)
            S_IDLE: begin
                if (start_rise && !err_q) begin
                    if (ccr_q == '0) begin
                        ec_d = 1'b1;
                    end else begin
                        cnt_d   = plr_q;
                        rem_d   = ccr_q;
                        state_d = wrap ? S_WRAP : entry_st;
                    end
                end
            end
            S_PH1, S_PH2, S_PH3: begin
                if (ulr_q == llr_q) begin
                    // Degenerate range: every clock is a full (held) cycle.
                    cyc_end = 1'b1;
                end else begin
                    step_up = (state_q == S_PH2) ? first_dn : ~first_dn;
                    tgt     = (state_q == S_PH1) ? t1 :
                              (state_q == S_PH2) ? t2 : plr_q;
                    nxt     = step_up ? cnt_q + ONE : cnt_q - ONE;
                    cnt_d   = nxt;
                    dir_d   = step_up;
                    if (nxt == tgt) begin
                        // PH3 is empty when PLR equals the PH2 target.
                        if (state_q == S_PH3 || (state_q == S_PH2 && t2 == plr_q))
                            cyc_end = 1'b1;
                        else
                            state_d = (state_q == S_PH1) ? S_PH2 : S_PH3;
                    end
                end
            end
            S_WRAP: begin
                step_up = ~first_dn;
                if (step_up) nxt = (cnt_q == ulr_q) ? llr_q : cnt_q + ONE;
                else         nxt = (cnt_q == llr_q) ? ulr_q : cnt_q - ONE;
                cnt_d   = nxt;
                dir_d   = step_up;
                cyc_end = (nxt == plr_q);
            end
            default: state_d = S_IDLE;
        endcase

        if (cyc_end) begin
            if (rem_q > CONE) begin
                rem_d = rem_q - CONE;
                if (state_q != S_WRAP) state_d = entry_st;
            end else begin
                rem_d   = '0;
                ec_d    = 1'b1;
                state_d = S_IDLE;
            end
        end

        // Abort freezes count/REM and suppresses the end-of-count pulse.
        if (busy && abort_in) begin
            state_d = S_IDLE;
            cnt_d   = cnt_q;
            dir_d   = dir_q;
            rem_d   = rem_q;
            ec_d    = 1'b0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state_q  <= S_IDLE;
            plr_q    <= '0;
            ulr_q    <= '1;
            llr_q    <= '0;
            ccr_q    <= '0;
            ctrl_q   <= '0;
            rem_q    <= '0;
            cnt_q    <= '0;
            dir_q    <= 1'b0;
            err_q    <= 1'b0;
            ec_q     <= 1'b0;
            dout_q   <= '0;
            start_q  <= 1'b0;
            wr_ign_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            plr_q    <= plr_d;
            ulr_q    <= ulr_d;
            llr_q    <= llr_d;
            ccr_q    <= ccr_d;
            ctrl_q   <= ctrl_d;
            rem_q    <= rem_d;
            cnt_q    <= cnt_d;
            dir_q    <= dir_d;
            err_q    <= err_d;
            ec_q     <= ec_d;
            dout_q   <= dout_d;
            start_q  <= start_d;
            wr_ign_q <= wr_ign_d;
        end
    end

`ifdef COUNTER_IRQ_EN
    logic irq_q, irq_d;

    // Set beats clear when both land on the same edge.
    assign irq_d = ec_q | (irq_q & ~(wr_en && addr_in == A_STAT));

    always_ff @(posedge clk_in) begin
        if (reset_in) irq_q <= 1'b0;
        else          irq_q <= irq_d;
    end

    assign irq_out = irq_q;
`endif

    assign dout      = dout_q;
    assign count_out = cnt_q;
    assign busy_out  = busy;
    assign dir_out   = dir_q;
    assign err_out   = err_q;
    assign ec_out    = ec_q;

endmodule

// File: tb/tb_prog_updown_counter.sv
// Bench for prog_updown_counter: directed register/boundary steps plus
// randomized runs checked against a list-based model of the count sequence.
module tb_prog_updown_counter;

    typedef int iq_t[$];

    logic       clk_in = 1'b0;
    logic       reset_in, ncs_in, nwr_in, nrd_in, start_in, abort_in;
    logic [2:0] addr_in;
    logic [7:0] din, dout, count_out;
    logic       busy_out, dir_out, err_out, ec_out;
`ifdef COUNTER_IRQ_EN
    logic       irq_out;
`endif

    int n_checks = 0;
    int n_err    = 0;

    prog_updown_counter #(.WIDTH(8), .CYC_W(8), .ADDR_W(3)) dut (
        .clk_in(clk_in), .reset_in(reset_in), .ncs_in(ncs_in), .nwr_in(nwr_in),
        .nrd_in(nrd_in), .addr_in(addr_in), .din(din), .dout(dout),
        .start_in(start_in), .abort_in(abort_in), .count_out(count_out),
        .busy_out(busy_out), .dir_out(dir_out), .err_out(err_out), .ec_out(ec_out)
`ifdef COUNTER_IRQ_EN
        , .irq_out(irq_out)
`endif
    );

    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input int a, input int d);
        ncs_in = 1'b0; nwr_in = 1'b0; addr_in = 3'(a); din = 8'(d);
        tick();
        ncs_in = 1'b1; nwr_in = 1'b1;
    endtask

    task automatic bus_read(input int a, output logic [7:0] d);
        ncs_in = 1'b0; nrd_in = 1'b0; addr_in = 3'(a);
        tick();
        d = dout;
        ncs_in = 1'b1; nrd_in = 1'b1;
    endtask

    // One full cycle of counts, one entry per clock, built from the rules.
    function automatic iq_t build_seq(int plr, int ulr, int llr, bit fdn, bit wrp);
        iq_t q;
        int  v;
        int  len;
        v = plr;
        if (wrp) begin
            len = ulr - llr + 1;
            for (int i = 0; i < len; i++) begin
                if (fdn) v = llr + (v - llr - 1 + len) % len;
                else     v = llr + (v - llr + 1) % len;
                q.push_back(v);
            end
        end else if (ulr == llr) begin
            q.push_back(plr);
        end else if (!fdn) begin
            while (v < ulr) begin v++; q.push_back(v); end
            while (v > llr) begin v--; q.push_back(v); end
            while (v < plr) begin v++; q.push_back(v); end
        end else begin
            while (v > llr) begin v--; q.push_back(v); end
            while (v < ulr) begin v++; q.push_back(v); end
            while (v > plr) begin v--; q.push_back(v); end
        end
        return q;
    endfunction

    task automatic pulse_start();
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
    endtask

    task automatic run_cfg(input int plr, input int ulr, input int llr, input int ctrl, input int ccr);
        iq_t        seq;
        int         prev;
        bit         last, hold;
        logic [7:0] rd;
        bus_write(0, plr); bus_write(1, ulr); bus_write(2, llr);
        bus_write(3, ccr); bus_write(4, ctrl);
        tick(); tick();
        check("cfg_err", 32'(err_out), 0);
        seq  = build_seq(plr, ulr, llr, ctrl[0], ctrl[1]);
        hold = (ulr == llr) && !ctrl[1];
        pulse_start();
        check("start_cnt", 32'(count_out), 32'(plr));
        check("start_busy", 32'(busy_out), 1);
        prev = plr;
        for (int c = 0; c < ccr; c++) begin
            for (int i = 0; i < seq.size(); i++) begin
                tick();
                last = (c == ccr - 1) && (i == seq.size() - 1);
                check("step_cnt", 32'(count_out), 32'(seq[i]));
                if (!hold) begin
                    if (ctrl[1]) check("step_dir", 32'(dir_out), 32'(!ctrl[0]));
                    else         check("step_dir", 32'(dir_out), 32'(seq[i] > prev));
                end
                check("step_ec", 32'(ec_out), 32'(last));
                check("step_busy", 32'(busy_out), 32'(!last));
                prev = seq[i];
            end
        end
        tick();
        check("post_ec", 32'(ec_out), 0);
        check("post_cnt", 32'(count_out), 32'(plr));
        bus_read(7, rd);
        check("post_rem", 32'(rd), 0);
    endtask

    task automatic check_reset_regs();
        logic [7:0] rd;
        int exp_v[8] = '{0, 255, 0, 0, 0, 0, 0, 0};
        for (int a = 0; a < 8; a++) begin
            bus_read(a, rd);
            check($sformatf("rst_reg%0d", a), 32'(rd), 32'(exp_v[a]));
        end
    endtask

    initial begin
        logic [7:0] rd, rd2, held;
        int         plr, ulr, llr;

        reset_in = 1'b1; ncs_in = 1'b1; nwr_in = 1'b1; nrd_in = 1'b1;
        addr_in = '0; din = '0; start_in = 1'b0; abort_in = 1'b0;
        tick(); tick();
        check("rst_cnt", 32'(count_out), 0);
        check("rst_busy", 32'(busy_out), 0);
        check("rst_ec", 32'(ec_out), 0);
        check("rst_dout", 32'(dout), 0);
        reset_in = 1'b0;
        tick();
        check_reset_regs();
        tick();
        check("dout_hold", 32'(dout), 0);

        // Bounce up-first and wrap down-first examples
        run_cfg(5, 8, 3, 0, 1);
        run_cfg(5, 8, 3, 3, 2);
        run_cfg(5, 8, 3, 1, 2);
        run_cfg(8, 8, 3, 0, 1);
        run_cfg(3, 8, 3, 1, 1);
        run_cfg(4, 4, 4, 0, 3);
        run_cfg(128, 255, 0, 0, 1);

        // Limit error blocks start
        bus_write(0, 2); bus_write(1, 8); bus_write(2, 3);
        tick();
        check("err_set", 32'(err_out), 1);
        pulse_start();
        check("err_busy", 32'(busy_out), 0);
        check("err_ec", 32'(ec_out), 0);
        bus_read(5, rd);
        check("err_status", 32'(rd[3:1]), 32'(3'b001));

        // CCR=0: single pulse, no run
        bus_write(0, 5); bus_write(3, 0);
        tick(); tick();
        check("ccr0_err", 32'(err_out), 0);
        pulse_start();
        check("ccr0_ec", 32'(ec_out), 1);
        check("ccr0_busy", 32'(busy_out), 0);
        tick();
        check("ccr0_ec_off", 32'(ec_out), 0);

        // Dropped write while busy, wr_ign, abort
        bus_write(0, 100); bus_write(1, 200); bus_write(2, 0);
        bus_write(3, 2); bus_write(4, 0);
        tick(); tick();
        pulse_start();
        tick(); tick();
        bus_write(0, 7);
        bus_read(0, rd);
        check("busy_wr_drop", 32'(rd), 100);
        bus_read(5, rd);
        check("wr_ign_set", 32'(rd[3:2]), 32'(2'b11));
        bus_read(5, rd);
        check("wr_ign_clr", 32'(rd[3:2]), 32'(2'b01));
        held = count_out;
        abort_in = 1'b1;
        tick();
        abort_in = 1'b0;
        check("abort_busy", 32'(busy_out), 0);
        check("abort_cnt", 32'(count_out), 32'(held));
        check("abort_ec", 32'(ec_out), 0);
        tick();
        check("abort_ec2", 32'(ec_out), 0);
        bus_read(7, rd);
        check("abort_rem", 32'(rd), 2);

        // Reset mid-count
        pulse_start();
        tick(); tick(); tick();
        check("mid_busy", 32'(busy_out), 1);
        check("mid_dir", 32'(dir_out), 1);
        reset_in = 1'b1;
        tick();
        reset_in = 1'b0;
        check("mrst_cnt", 32'(count_out), 0);
        check("mrst_busy", 32'(busy_out), 0);
        check("mrst_dir", 32'(dir_out), 0);
        check("mrst_ec", 32'(ec_out), 0);
        check("mrst_dout", 32'(dout), 0);
        tick();
        check("mrst_ec2", 32'(ec_out), 0);
        check_reset_regs();

        // Randomized configurations
        for (int n = 0; n < 24; n++) begin
            llr = int'($urandom_range(0, 250));
            ulr = llr + int'($urandom_range(0, 5));
            plr = int'($urandom_range(llr, ulr));
            run_cfg(plr, ulr, llr, int'($urandom_range(0, 3)), int'($urandom_range(1, 3)));
        end

`ifdef COUNTER_IRQ_EN
        run_cfg(5, 8, 3, 0, 1);
        check("irq_set", 32'(irq_out), 1);
        bus_write(5, 0);
        check("irq_clr", 32'(irq_out), 0);
        bus_write(3, 0);
        tick(); tick();
        pulse_start();
        check("irq_ec", 32'(ec_out), 1);
        bus_write(5, 0);
        check("irq_set_wins", 32'(irq_out), 1);
        tick();
        bus_write(5, 0);
        check("irq_clr2", 32'(irq_out), 0);
`endif

        rd2 = 8'h00;
        check("final_busy", 32'(busy_out), 32'(rd2[0]));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/prog_updown_counter.md
Name: prog_updown_counter

Overview:
- Parametrised next-generation programmable up/down counter with a register file programmed over a chip-select/read/write bus.
- Counts PLR→ULR→LLR→PLR (bounce) or circularly between LLR..ULR (wrap) for CCR cycles, then pulses end-of-cycle.
- Adds over the previous generation: generic width, a control register (mode and first direction), status/count readback, abort, and a clean single-driver FSM.
- Sits as a memory-mapped peripheral beside the host bus decoder.

Parameters:
WIDTH, 8, count and data width
CYC_W, 8, width of cycle-count register CCR
ADDR_W, 3, register address width (8 locations)

Ports:
clk_in  input  1  clock, all logic on rising edge
reset_in  input  1  synchronous, active-high reset
ncs_in  input  1  chip select, active low
nwr_in  input  1  write strobe, active low
nrd_in  input  1  read strobe, active low
addr_in  input  ADDR_W  register address
din  input  WIDTH  write data
dout  output  WIDTH  registered read data
start_in  input  1  start request, rising-edge detected
abort_in  input  1  abort level, active high
count_out  output  WIDTH  current count
busy_out  output  1  counting in progress
dir_out  output  1  1 = last step up, 0 = last step down
err_out  output  1  limit configuration error
ec_out  output  1  one-cycle end-of-count pulse

Behaviour:
- One clock, clk_in. reset_in is synchronous, active-high.
- Reset values: PLR=0, ULR=all ones, LLR=0, CCR=0, CTRL=0, REM=0. count_out=0, busy_out=0, dir_out=0, err_out=0, ec_out=0, dout=0, start edge register=0.
- Reset asserted mid-count: the next edge returns everything to these values; ec_out is not pulsed.
- Address map:
  - 0 PLR, 1 ULR, 2 LLR, 3 CCR (CYC_W bits, zero-extended on read).
  - 4 CTRL: bit0 FIRST_DN (0 = up first), bit1 WRAP.
  - 5 STATUS (read-only): {wr_ign, busy, err, dir} in bits 3..0.
  - 6 COUNT (read-only), 7 REM = remaining cycles (read-only).
- Write: on an edge with ncs_in=0, nwr_in=0, nrd_in=1, din goes to addr_in.
  - Writes to 5..7 are ignored.
  - Any write while busy is dropped and sets sticky wr_ign.
- Read: ncs_in=0, nrd_in=0, nwr_in=1 loads dout at that edge (1-cycle latency); otherwise dout holds.
  - Reading STATUS clears wr_ign.
  - nwr_in=0 and nrd_in=0 together: no access.
- err_out, registered each clock: 1 if PLR<LLR, PLR>ULR or LLR>ULR.
- FSM states: IDLE, PH1, PH2, PH3, WRAPRUN.
- Start: in IDLE, a start_in rising edge with err_out=0:
  - CCR=0: ec_out=1 for one cycle, stay IDLE.
  - CCR>0: count_out=PLR, REM=CCR, busy=1, enter PH1 (bounce) or WRAPRUN (wrap).
  - Start while busy, or with err_out=1: ignored.
- Bounce, up-first: PH1 increments to ULR, PH2 decrements to LLR, PH3 increments to PLR. Down-first swaps the PH1/PH2 targets and directions.
  - One step per clock; phase changes without a dwell cycle.
  - Cycle length = 2*(ULR-LLR) clocks; if ULR=LLR, 1 clock (hold).
- Wrap: steps in the FIRST_DN direction; ULR+1→LLR (up) or LLR-1→ULR (down). Cycle length = ULR-LLR+1 clocks.
- Cycle end (count returns to PLR):
  - REM>1: decrement REM and continue.
  - REM=1: REM=0, ec_out=1 for one cycle, busy=0, IDLE, count_out holds PLR.
- dir_out updates on every step and holds in IDLE.
- abort_in=1 while busy: IDLE on the next edge, count holds, REM holds, no ec_out.
- Arithmetic is WIDTH-bit unsigned; no wrap past 0 or all-ones can occur when err_out=0.
- Configuration errors are checked only at start; they cannot change while busy because writes are dropped.

Optional Feature:
- Macro COUNTER_IRQ_EN.
- Defined: adds output irq_out (1 bit, reset 0), a sticky level set by ec_out. It is cleared by any bus write to address 5 or by reset; a set on the same edge as a clear wins.
- Undefined: no irq_out port and no associated logic.

Test Plan:
- Reset, read all 8 addresses → PLR=0, ULR=255, LLR=0, CCR=0, CTRL=0, STATUS=0, COUNT=0, REM=0.
- PLR=5, ULR=8, LLR=3, CCR=1, CTRL=0, start → count 5,6,7,8,7,6,5,4,3,4,5 (10 steps), dir_out follows, ec_out=1 once, busy low, count_out=5.
- Same setup, CTRL=3 (wrap, down-first), CCR=2 → 5,4,3,8,7,6,5,4,3,8,7,6,5; ec_out after 12 steps.
- PLR=2, LLR=3 → err_out=1; start ignored. CCR=0 with valid limits → single ec_out, busy stays 0.
- Mid-count: write PLR → value unchanged, STATUS wr_ign=1 (cleared after read). abort_in → IDLE with no ec_out. reset_in mid-count → reset values next edge.
- With COUNTER_IRQ_EN defined: completion sets irq_out, write to addr 5 clears it; simultaneous ec_out and clear → irq_out=1.
